tile_ram_write_ctrl: RTL and testbench



---
 rtl/etch_pkg.sv | 27 ++
 rtl/tile_sweep_counter.sv | 39 +++
 rtl/tile_ram_write_ctrl.sv | 121 ++++++++++++
 tb/tb_tile_ram_write_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/etch_pkg.sv
// Shared constants for the 80x30 tile RAM: geometry, tile codes, write-FSM states
// and the {row,column} address packing that the display read side also uses.
package etch_pkg;

  localparam int XW     = 7;
  localparam int YW     = 5;
  localparam int DATA_W = 7;
  localparam int ADDR_W = XW + YW;

  localparam logic [XW-1:0]     MAX_X      = 7'd79;
  localparam logic [YW-1:0]     MAX_Y      = 5'd29;
  localparam logic [DATA_W-1:0] TRACE_CODE = 7'h01;
  localparam logic [DATA_W-1:0] BLANK_CODE = 7'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } wr_state_t;

  // Row in the upper bits so a row is a contiguous 128-entry block.
  function automatic logic [ADDR_W-1:0] pack_addr(input logic [YW-1:0] row,
                                                  input logic [XW-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/tile_sweep_counter.sv
// Row-major tile counter for the clear sweep: start zeroes it, advance steps one
// tile, last flags the final tile (LAST_X, LAST_Y).
module tile_sweep_counter
  import etch_pkg::*;
#(
  parameter logic [XW-1:0] LAST_X = MAX_X,
  parameter logic [YW-1:0] LAST_Y = MAX_Y
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  input  logic          start,
  input  logic          advance,
  output logic [XW-1:0] sx,
  output logic [YW-1:0] sy,
  output logic          last
);

  logic [XW-1:0] sx_reg;
  logic [YW-1:0] sy_reg;

  always_ff @(posedge clk_100MHz) begin
    if (reset || start) begin
      sx_reg <= '0;
      sy_reg <= '0;
    end else if (advance) begin
      if (sx_reg == LAST_X) begin
        sx_reg <= '0;
        sy_reg <= (sy_reg == LAST_Y) ? '0 : sy_reg + 1'b1;
      end else begin
        sx_reg <= sx_reg + 1'b1;
      end
    end
  end

  assign sx   = sx_reg;
  assign sy   = sy_reg;
  assign last = (sx_reg == LAST_X) && (sy_reg == LAST_Y);

endmodule

// File: rtl/tile_ram_write_ctrl.sv
// Port-A write sequencer for the tile RAM: cursor trace writes in IDLE, a full
// row-major clear sweep on a clear_req rising edge. Define CLEAR_ON_RESET_EN to sweep after reset.
module tile_ram_write_ctrl
  import etch_pkg::*;
(
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              trace_en,
  input  logic [XW-1:0]     cur_x,
  input  logic [YW-1:0]     cur_y,
  output logic              we,
  output logic [ADDR_W-1:0] addr_w,
  output logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              clear_done
);

  wr_state_t         state_reg, state_next;
  logic              clear_req_q_reg;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] din_reg, din_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  logic              clr_rise, start_clear;
  logic              sweep_start, sweep_adv, sweep_last;
  logic [XW-1:0]     sweep_x;
  logic [YW-1:0]     sweep_y;

  assign clr_rise = clear_req & ~clear_req_q_reg;

`ifdef CLEAR_ON_RESET_EN
  // High only on the first cycle after reset releases; FSM is in IDLE then.
  logic auto_clear_reg;
  always_ff @(posedge clk_100MHz) begin
    auto_clear_reg <= reset;
  end
  assign start_clear = clr_rise | auto_clear_reg;
`else
  assign start_clear = clr_rise;
`endif

  tile_sweep_counter #(
    .LAST_X (MAX_X),
    .LAST_Y (MAX_Y)
  ) u_sweep (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .start      (sweep_start),
    .advance    (sweep_adv),
    .sx         (sweep_x),
    .sy         (sweep_y),
    .last       (sweep_last)
  );

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_reg       <= IDLE;
      clear_req_q_reg <= 1'b0;
      we_reg          <= 1'b0;
      addr_reg        <= '0;
      din_reg         <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      clear_req_q_reg <= clear_req;
      we_reg          <= we_next;
      addr_reg        <= addr_next;
      din_reg         <= din_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    we_next     = 1'b0;
    addr_next   = addr_reg;
    din_next    = din_reg;
    busy_next   = 1'b0;
    done_next   = 1'b0;
    sweep_start = 1'b0;
    sweep_adv   = 1'b0;
    case (state_reg)
      IDLE: begin
        we_next   = trace_en && (cur_x <= MAX_X) && (cur_y <= MAX_Y);
        addr_next = pack_addr(cur_y, cur_x);
        din_next  = TRACE_CODE;
        // Clear beats a simultaneous trace: suppress that cycle's write.
        if (start_clear) begin
          state_next  = CLEAR;
          we_next     = 1'b0;
          sweep_start = 1'b1;
        end
      end
      CLEAR: begin
        we_next   = 1'b1;
        addr_next = pack_addr(sweep_y, sweep_x);
        din_next  = BLANK_CODE;
        busy_next = 1'b1;
        sweep_adv = 1'b1;
        if (sweep_last) state_next = DONE;
      end
      DONE: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign we         = we_reg;
  assign addr_w     = addr_reg;
  assign din        = din_reg;
  assign busy       = busy_reg;
  assign clear_done = done_reg;

endmodule

// File: tb/tb_tile_ram_write_ctrl.sv
// Self-checking bench for tile_ram_write_ctrl: vector table for trace writes,
// random trace stimulus against an arithmetic model, and full clear-sweep sequences.
module tb_tile_ram_write_ctrl;
  import etch_pkg::*;

  localparam int NX = 80;
  localparam int NY = 30;
  localparam int N_TILES = NX * NY;

  logic              clk_100MHz = 1'b0;
  logic              reset;
  logic              clear_req;
  logic              trace_en;
  logic [XW-1:0]     cur_x;
  logic [YW-1:0]     cur_y;
  logic              we;
  logic [ADDR_W-1:0] addr_w;
  logic [DATA_W-1:0] din;
  logic              busy;
  logic              clear_done;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  tile_ram_write_ctrl dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .clear_req  (clear_req),
    .trace_en   (trace_en),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .we         (we),
    .addr_w     (addr_w),
    .din        (din),
    .busy       (busy),
    .clear_done (clear_done)
  );

  typedef struct {
    bit trace;
    int x;
    int y;
    bit exp_we;
    int exp_addr;
  } vec_t;

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Runs a sweep and checks every write against the row-major tile order.
  // abort_at > 0 returns right after that many writes have been checked.
  task automatic sweep(input int abort_at, input bit edge_start);
    int bad, first_k, exp_addr;
    logic [31:0] first_info;
    bad = 0; first_k = -1; first_info = 0;
    if (edge_start) clear_req = 1'b1;
    // Simultaneous trace request must lose to the clear.
    trace_en = 1'b1; cur_x = 7'd10; cur_y = 5'd3;
    tick();
    chk("sweep_start_we", {31'd0, we}, 32'd0);
    for (int k = 0; k < N_TILES; k++) begin
      tick();
      exp_addr = (k / NX) * 128 + (k % NX);
      if (!(we === 1'b1 && addr_w === exp_addr[ADDR_W-1:0] && din === BLANK_CODE &&
            busy === 1'b1 && clear_done === 1'b0)) begin
        if (bad == 0) begin
          first_k = k;
          first_info = {8'(we), 4'(busy), 4'(clear_done), 16'(addr_w)};
        end
        bad++;
      end
      trace_en = 1'($urandom_range(0, 1));
      cur_x = 7'($urandom_range(0, NX - 1));
      cur_y = 5'($urandom_range(0, NY - 1));
      if (abort_at > 0 && k + 1 == abort_at) break;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL sweep_seq: %0d bad write cycles, first at write %0d (we/busy/done/addr=0x%0h), required 0",
               bad, first_k, first_info);
    end
    $display("sweep: %0d writes checked, %0d bad", (abort_at > 0) ? abort_at : N_TILES, bad);
    if (abort_at > 0) return;
    tick();
    chk("done_pulse", {31'd0, clear_done}, 32'd1);
    chk("done_we", {31'd0, we}, 32'd0);
    chk("done_busy", {31'd0, busy}, 32'd0);
    trace_en = 1'b1; cur_x = 7'd40; cur_y = 5'd20;
    tick();
    chk("done_single", {31'd0, clear_done}, 32'd0);
    chk("resume_we", {31'd0, we}, 32'd1);
    chk("resume_addr", 32'(addr_w), 32'(20 * 128 + 40));
    chk("resume_din", 32'(din), 32'(TRACE_CODE));
  endtask

  initial begin
    vec_t vecs[7];
    int extra;
    bit te;
    int rx, ry;

    vecs[0] = '{1'b1, 35, 15, 1'b1, 32'h7A3};
    vecs[1] = '{1'b0, 35, 15, 1'b0, 32'h7A3};
    vecs[2] = '{1'b1, 80,  0, 1'b0, 32'h050};
    vecs[3] = '{1'b1,  0, 30, 1'b0, 32'hF00};
    vecs[4] = '{1'b1, 79, 29, 1'b1, 32'hECF};
    vecs[5] = '{1'b1,  0,  0, 1'b1, 32'h000};
    vecs[6] = '{1'b1, 127, 31, 1'b0, 32'hFFF};

    reset = 1'b1; clear_req = 1'b0; trace_en = 1'b1; cur_x = 7'd5; cur_y = 5'd5;
    tick(); tick(); tick();
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_addr", 32'(addr_w), 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, clear_done}, 32'd0);
    reset = 1'b0;

`ifdef CLEAR_ON_RESET_EN
    sweep(0, 1'b0);
`endif

    foreach (vecs[i]) begin
      trace_en = vecs[i].trace; cur_x = 7'(vecs[i].x); cur_y = 5'(vecs[i].y);
      tick();
      chk("vec_we", {31'd0, we}, {31'd0, vecs[i].exp_we});
      chk("vec_addr", 32'(addr_w), 32'(vecs[i].exp_addr));
      if (vecs[i].exp_we) chk("vec_din", 32'(din), 32'(TRACE_CODE));
      $display("vec %0d: trace=%0d x=%0d y=%0d -> we=%0d addr=0x%0h", i, vecs[i].trace,
               vecs[i].x, vecs[i].y, we, addr_w);
    end

    for (int i = 0; i < 200; i++) begin
      te = 1'($urandom_range(0, 1));
      rx = $urandom_range(0, 99);
      ry = $urandom_range(0, 31);
      trace_en = te; cur_x = 7'(rx); cur_y = 5'(ry);
      tick();
      chk("rand_we", {31'd0, we}, {31'd0, (te && rx < NX && ry < NY)});
      chk("rand_addr", 32'(addr_w), 32'(ry * 128 + rx));
      $display("rand %0d: trace=%0d x=%0d y=%0d -> we=%0d", i, te, rx, ry, we);
    end

    trace_en = 1'b0;
    tick();
    sweep(0, 1'b1);

    // clear_req still held high: no second sweep may start.
    trace_en = 1'b0;
    extra = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (busy !== 1'b0 || we !== 1'b0) extra++;
    end
    chk("no_resweep", 32'(extra), 32'd0);
    clear_req = 1'b0;
    tick();

    sweep(1000, 1'b1);
    reset = 1'b1; clear_req = 1'b0;
    tick();
    chk("abort_we", {31'd0, we}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, clear_done}, 32'd0);
    reset = 1'b0;
`ifdef CLEAR_ON_RESET_EN
    sweep(0, 1'b0);
`else
    trace_en = 1'b0;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy !== 1'b0 || we !== 1'b0 || clear_done !== 1'b0) extra++;
    end
    chk("abort_idle", 32'(extra), 32'd0);
    sweep(0, 1'b1);
`endif
    clear_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
